rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
Round-robin arbiter that shares the register file's single write port (we3/addr3/wd3) between NUM_REQ writeback requesters (ALU, load unit, CSR/debug).
- Each requester uses a valid/ready handshake.
- One write is granted per cycle and registered into a single output stage that drives the register file write port directly.
- The registered stage is also exported as the pending-write bypass source for read-port forwarding.

Parameters:
NUM_REQ, 3, number of writeback requesters (2..8)
ADDR_W, 5, register address width
DATA_W, 32, write data width

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_stall  input  1  global hold; no grants while high
i_req_valid  input  NUM_REQ  per-requester write request
i_req_addr  input  NUM_REQ*ADDR_W  packed destination addresses, requester k at bits [k*ADDR_W +: ADDR_W]
i_req_data  input  NUM_REQ*DATA_W  packed write data, requester k at [k*DATA_W +: DATA_W]
o_req_ready  output  NUM_REQ  one-hot grant (combinational)
o_we3  output  1  register file write enable (registered)
o_addr3  output  ADDR_W  register file write address (registered)
o_wd3  output  DATA_W  register file write data (registered)
o_rr_ptr  output  clog2(NUM_REQ)  current highest-priority requester (debug/verif)

Behaviour:
- Reset (async, i_rst_n=0): o_we3=0, o_addr3=0, o_wd3=0, o_rr_ptr=0. o_req_ready=0 while in reset. Reset mid-transfer drops any granted-but-not-yet-registered write.
- Grant (combinational):
  - If i_stall=1 or no valid, o_req_ready=0.
  - Otherwise grant the first valid requester scanning from o_rr_ptr upward, mod NUM_REQ.
  - o_req_ready is one-hot or zero, never multi-hot.
- Accept = i_req_valid[k] & o_req_ready[k]. Requester protocol:
  - valid, addr and data stay stable until accepted.
  - valid is not dependent on ready.
- Output stage, per clock edge:
  - On accept: o_addr3<=addr_k, o_wd3<=data_k, o_we3<=(addr_k!=0).
  - No accept: o_we3<=0; o_addr3/o_wd3 hold.
- x0 writes: accepted and consumed (ready asserted) but produce o_we3=0.
- Latency: accept in cycle t -> o_we3 high in cycle t+1 -> register file captures at end of t+1 -> new value on read ports from cycle t+2.
- Bypass: during cycle t+1, o_we3/o_addr3/o_wd3 define the in-flight write; read-side forwarding compares against them.
- Pointer:
  - After an accept by k, o_rr_ptr<=(k+1) mod NUM_REQ, with explicit wrap at NUM_REQ-1 -> 0.
  - No accept: pointer holds, including while stalled.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles of stall-free operation.
- Same-address requests from two requesters: serviced in grant order; last accepted wins.
- Back-to-back accepts: allowed every cycle; o_we3 may stay high continuously.
- i_stall rising while a write is registered: that write still completes; only new grants are blocked.

Decomposition:
- Shared package (rf_pkg): ADDR_W, DATA_W, REG_ZERO=0 constant.
- Sub-module rr_arbiter: parameterised NUM_REQ round-robin grant plus pointer update. Reusable for the memory-port arbiter.
- Top level adds the mux, output register, and x0 suppression.

Test Plan:
- Reset: assert i_rst_n=0 mid-stream with req_valid=3'b111 -> o_we3=0, o_addr3=0, o_wd3=0, o_rr_ptr=0, o_req_ready=0 immediately, without waiting for a clock edge.
- Single requester: req1 valid addr=5 data=0xDEADBEEF at t -> ready[1]=1 at t; next cycle o_we3=1, o_addr3=5, o_wd3=0xDEADBEEF; register read of x5=0xDEADBEEF at t+2.
- All three valid continuously from ptr=0 -> grants 0,1,2,0,1,2 on consecutive cycles; o_rr_ptr 1,2,0,1,2,0 (wrap-around).
- x0 write: req0 addr=0 data=0x1234 -> ready[0]=1; next cycle o_we3=0; x0 still reads 0; pointer advances to 1.
- Stall: i_stall=1 for 3 cycles with req2 valid -> ready=0, o_we3=0 after one cycle, pointer unchanged; on release req2 is granted the same cycle.
- Same address: req0 addr=7 data=A and req1 addr=7 data=B, ptr=0 -> A written at t+1, B at t+2; final x7=B.

Source files
------------

// File: rtl/rf_pkg.sv
// Register-file writeback constants shared by the writeback arbiter and its neighbours.
package rf_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/rr_arbiter.sv
// Parameterised round-robin grant with a registered highest-priority pointer.
// Valid/ready: i_req[k] is a request; o_gnt[k] is its ready, one-hot or zero, and a grant is an accept.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [PTR_W-1:0]   o_gnt_idx,
  output logic               o_any,
  output logic [PTR_W-1:0]   o_ptr
);

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   idx_hi, idx_lo, gnt_idx;
  logic [NUM_REQ-1:0] req_hi;
  logic               any_hi, any_lo;

  // Requests at or above the pointer win; otherwise wrap to the lowest request.
  always_comb begin
    req_hi = '0;
    idx_hi = '0;
    idx_lo = '0;
    any_hi = 1'b0;
    any_lo = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_hi[i] = i_req[i] && (i >= int'(ptr_q));
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_hi[i]) begin
        idx_hi = PTR_W'(i);
        any_hi = 1'b1;
      end
      if (i_req[i]) begin
        idx_lo = PTR_W'(i);
        any_lo = 1'b1;
      end
    end
    gnt_idx = any_hi ? idx_hi : idx_lo;
  end

  always_comb begin
    o_gnt = '0;
    o_any = i_en & any_lo;
    ptr_d = ptr_q;
    if (o_any) begin
      o_gnt[gnt_idx] = 1'b1;
      ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign o_gnt_idx = gnt_idx;
  assign o_ptr     = ptr_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register file write port between NUM_REQ writeback requesters.
// The registered write stage also serves as the in-flight bypass source for read forwarding.
module rf_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = rf_pkg::ADDR_W,
  parameter int DATA_W  = rf_pkg::DATA_W,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_stall,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic                      o_we3,
  output logic [ADDR_W-1:0]         o_addr3,
  output logic [DATA_W-1:0]         o_wd3,
  output logic [PTR_W-1:0]          o_rr_ptr
);
  import rf_pkg::*;

  logic [NUM_REQ-1:0] gnt;
  logic [PTR_W-1:0]   gnt_idx;
  logic               accept;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wd_q, wd_d;

  // Gating with i_rst_n keeps ready low for the whole reset, not just after an edge.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_en      (~i_stall & i_rst_n),
    .i_req     (i_req_valid),
    .o_gnt     (gnt),
    .o_gnt_idx (gnt_idx),
    .o_any     (accept),
    .o_ptr     (o_rr_ptr)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        sel_addr = i_req_addr[k*ADDR_W +: ADDR_W];
        sel_data = i_req_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // x0 writes are consumed but never reach the register file.
  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    wd_d   = wd_q;
    if (accept) begin
      addr_d = sel_addr;
      wd_d   = sel_data;
      we_d   = (sel_addr != ADDR_W'(REG_ZERO));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      wd_q   <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      wd_q   <= wd_d;
    end
  end

  assign o_req_ready = gnt;
  assign o_we3       = we_q;
  assign o_addr3     = addr_q;
  assign o_wd3       = wd_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus held-valid random traffic.
module tb_rf_wb_arbiter;
  localparam int NR = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int PW = 2;
  localparam int W  = 1 + AW + DW + PW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           stall = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]  o_req_ready;
  logic           o_we3;
  logic [AW-1:0]  o_addr3;
  logic [DW-1:0]  o_wd3;
  logic [PW-1:0]  o_rr_ptr;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .PTR_W(PW)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_stall     (stall),
    .i_req_valid (req_valid),
    .i_req_addr  (req_addr),
    .i_req_data  (req_data),
    .o_req_ready (o_req_ready),
    .o_we3       (o_we3),
    .o_addr3     (o_addr3),
    .o_wd3       (o_wd3),
    .o_rr_ptr    (o_rr_ptr)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic mon_en = 1'b0;

  logic [W-1:0] exp_q[$];
  int           due_q[$];
  logic [PW-1:0] m_ptr = '0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wd = '0;
  logic [NR-1:0] m_rdy = '0;
  logic [DW-1:0] rf_m [32];

  always @(posedge clk) cyc++;

  // Register file fed by the write port, used to check read-back values.
  always @(posedge clk) if (rst_n && o_we3) rf_m[o_addr3] <= o_wd3;

  // Scoreboard: every cycle compare ready against the model and pop due output-stage entries.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      checks++;
      if (o_req_ready !== m_rdy) begin
        failures++;
        $display("FAIL sb_ready cyc=%0d got=%b exp=%b", cyc, o_req_ready, m_rdy);
      end
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        logic [W-1:0] exp_v;
        logic [W-1:0] got_v;
        exp_v = exp_q.pop_front();
        void'(due_q.pop_front());
        got_v = {o_we3, o_addr3, o_wd3, o_rr_ptr};
        checks++;
        if (got_v !== exp_v) begin
          failures++;
          $display("FAIL sb_out cyc=%0d got we=%b a=%0d d=%h p=%0d exp we=%b a=%0d d=%h p=%0d",
                   cyc, got_v[W-1], got_v[W-2 -: AW], got_v[PW +: DW], got_v[PW-1:0],
                   exp_v[W-1], exp_v[W-2 -: AW], exp_v[PW +: DW], exp_v[PW-1:0]);
        end
      end
    end
  end

  task automatic model_reset();
    m_ptr = '0;
    m_addr = '0;
    m_wd = '0;
    m_rdy = '0;
    exp_q.delete();
    due_q.delete();
  endtask

  // Drive one cycle of requests just after the clock edge and push the expected output stage.
  task automatic drive(input logic [NR-1:0] v, input logic [NR*AW-1:0] a,
                       input logic [NR*DW-1:0] d, input logic st);
    logic acc;
    logic [AW-1:0] ak;
    logic [DW-1:0] dk;
    logic [PW-1:0] pk;
    @(posedge clk);
    #1;
    req_valid = v;
    req_addr = a;
    req_data = d;
    stall = st;
    m_rdy = '0;
    acc = 1'b0;
    ak = m_addr;
    dk = m_wd;
    pk = m_ptr;
    if (!st) begin
      for (int i = 0; i < NR; i++) begin
        int k;
        k = (int'(m_ptr) + i) % NR;
        if (!acc && v[k]) begin
          acc = 1'b1;
          m_rdy[k] = 1'b1;
          ak = a[k*AW +: AW];
          dk = d[k*DW +: DW];
          pk = (k == NR - 1) ? '0 : PW'(k + 1);
        end
      end
    end
    exp_q.push_back({acc && (ak != '0), ak, dk, pk});
    due_q.push_back(cyc + 1);
    m_addr = ak;
    m_wd = dk;
    m_ptr = pk;
  endtask

  task automatic test_reset();
    req_valid = '1;
    #12;
    checks++;
    if ({o_we3, o_addr3, o_wd3, o_rr_ptr} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got we=%b a=%0d d=%h p=%0d exp all 0", o_we3, o_addr3, o_wd3, o_rr_ptr);
    end
    checks++;
    if (o_req_ready !== 3'b000) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=000", o_req_ready);
    end
    @(negedge clk);
    #2;
    req_valid = '0;
    rst_n = 1'b1;
    model_reset();
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    drive(3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0}, 1'b0);
    #1;
    checks++;
    if (o_req_ready !== 3'b010) begin
      failures++;
      $display("FAIL single_ready got=%b exp=010", o_req_ready);
    end
    drive('0, '0, '0, 1'b0);
    #1;
    checks++;
    if (o_we3 !== 1'b1 || o_addr3 !== 5'd5 || o_wd3 !== 32'hDEADBEEF || o_rr_ptr !== 2'd2) begin
      failures++;
      $display("FAIL single_write got we=%b a=%0d d=%h p=%0d exp we=1 a=5 d=deadbeef p=2",
               o_we3, o_addr3, o_wd3, o_rr_ptr);
    end
    drive('0, '0, '0, 1'b0);
    #1;
    checks++;
    if (rf_m[5] !== 32'hDEADBEEF || o_we3 !== 1'b0) begin
      failures++;
      $display("FAIL single_readback got x5=%h we=%b exp x5=deadbeef we=0", rf_m[5], o_we3);
    end
  endtask

  task automatic test_x0();
    drive(3'b001, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'h1234}, 1'b0);
    #1;
    checks++;
    if (o_req_ready !== 3'b001) begin
      failures++;
      $display("FAIL x0_ready got=%b exp=001", o_req_ready);
    end
    drive('0, '0, '0, 1'b0);
    #1;
    checks++;
    if (o_we3 !== 1'b0 || o_rr_ptr !== 2'd1 || o_wd3 !== 32'h1234) begin
      failures++;
      $display("FAIL x0_write got we=%b p=%0d d=%h exp we=0 p=1 d=1234", o_we3, o_rr_ptr, o_wd3);
    end
    drive('0, '0, '0, 1'b0);
    #1;
    checks++;
    if (rf_m[0] !== 32'h0) begin
      failures++;
      $display("FAIL x0_readback got=%h exp=0", rf_m[0]);
    end
  endtask

  task automatic test_stall();
    drive(3'b001, {5'd0, 5'd0, 5'd3}, {32'h0, 32'h0, 32'hA5A50003}, 1'b0);
    for (int s = 0; s < 3; s++) begin
      drive(3'b100, {5'd9, 5'd0, 5'd0}, {32'h00000099, 32'h0, 32'h0}, 1'b1);
      #1;
      checks++;
      if (o_req_ready !== 3'b000 || o_rr_ptr !== 2'd1 || o_we3 !== (s == 0)) begin
        failures++;
        $display("FAIL stall_hold s=%0d got rdy=%b p=%0d we=%b exp rdy=000 p=1 we=%b",
                 s, o_req_ready, o_rr_ptr, o_we3, (s == 0));
      end
    end
    drive(3'b100, {5'd9, 5'd0, 5'd0}, {32'h00000099, 32'h0, 32'h0}, 1'b0);
    #1;
    checks++;
    if (o_req_ready !== 3'b100) begin
      failures++;
      $display("FAIL stall_release got=%b exp=100", o_req_ready);
    end
    drive('0, '0, '0, 1'b0);
    #1;
    checks++;
    if (o_we3 !== 1'b1 || o_addr3 !== 5'd9 || o_rr_ptr !== 2'd0) begin
      failures++;
      $display("FAIL stall_write got we=%b a=%0d p=%0d exp we=1 a=9 p=0", o_we3, o_addr3, o_rr_ptr);
    end
  endtask

  task automatic test_back_to_back();
    logic [NR-1:0] er;
    for (int j = 0; j < 6; j++) begin
      drive(3'b111, {5'd12, 5'd11, 5'd10}, {32'hC2, 32'hC1, 32'hC0}, 1'b0);
      #1;
      er = 3'b001 << (j % 3);
      checks++;
      if (o_req_ready !== er || o_rr_ptr !== PW'(j % 3)) begin
        failures++;
        $display("FAIL rr_grant j=%0d got rdy=%b p=%0d exp rdy=%b p=%0d", j, o_req_ready, o_rr_ptr, er, j % 3);
      end
    end
    drive('0, '0, '0, 1'b0);
    #1;
    checks++;
    if (o_we3 !== 1'b1 || o_addr3 !== 5'd12 || o_rr_ptr !== 2'd0) begin
      failures++;
      $display("FAIL rr_wrap got we=%b a=%0d p=%0d exp we=1 a=12 p=0", o_we3, o_addr3, o_rr_ptr);
    end
  endtask

  task automatic test_same_addr();
    drive(3'b011, {5'd0, 5'd7, 5'd7}, {32'h0, 32'hBBBB0002, 32'hAAAA0001}, 1'b0);
    drive(3'b010, {5'd0, 5'd7, 5'd7}, {32'h0, 32'hBBBB0002, 32'hAAAA0001}, 1'b0);
    #1;
    checks++;
    if (o_addr3 !== 5'd7 || o_wd3 !== 32'hAAAA0001) begin
      failures++;
      $display("FAIL same_first got a=%0d d=%h exp a=7 d=aaaa0001", o_addr3, o_wd3);
    end
    drive('0, '0, '0, 1'b0);
    #1;
    checks++;
    if (o_wd3 !== 32'hBBBB0002) begin
      failures++;
      $display("FAIL same_second got d=%h exp d=bbbb0002", o_wd3);
    end
    drive('0, '0, '0, 1'b0);
    #1;
    checks++;
    if (rf_m[7] !== 32'hBBBB0002) begin
      failures++;
      $display("FAIL same_final got x7=%h exp bbbb0002", rf_m[7]);
    end
  endtask

  task automatic test_random();
    logic [NR-1:0] pv;
    logic [NR*AW-1:0] pa;
    logic [NR*DW-1:0] pd;
    logic st;
    int wait_c[NR];
    int max_wait;
    pv = '0;
    pa = '0;
    pd = '0;
    max_wait = 0;
    for (int k = 0; k < NR; k++) wait_c[k] = 0;
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < NR; k++) begin
        if (!pv[k] && $urandom_range(0, 2) != 0) begin
          pv[k] = 1'b1;
          pa[k*AW +: AW] = AW'($urandom_range(0, 31));
          pd[k*DW +: DW] = $urandom();
        end
      end
      st = ($urandom_range(0, 7) == 0);
      drive(pv, pa, pd, st);
      #1;
      for (int k = 0; k < NR; k++) begin
        if (pv[k]) begin
          if (o_req_ready[k]) wait_c[k] = 0;
          else if (!st) begin
            wait_c[k]++;
            if (wait_c[k] > max_wait) max_wait = wait_c[k];
          end
        end
      end
      pv = pv & ~m_rdy;
    end
    drive('0, '0, '0, 1'b0);
    checks++;
    if (max_wait > NR - 1) begin
      failures++;
      $display("FAIL fairness got max_wait=%0d exp<=%0d", max_wait, NR - 1);
    end
  endtask

  task automatic test_reset_mid();
    drive(3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 1'b0);
    drive(3'b110, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_we3, o_addr3, o_wd3, o_rr_ptr} !== '0 || o_req_ready !== 3'b000) begin
      failures++;
      $display("FAIL reset_mid got we=%b a=%0d d=%h p=%0d rdy=%b exp all 0",
               o_we3, o_addr3, o_wd3, o_rr_ptr, o_req_ready);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #2;
    req_valid = '0;
    rst_n = 1'b1;
    drive(3'b100, {5'd4, 5'd0, 5'd0}, {32'h44, 32'h0, 32'h0}, 1'b0);
    drive('0, '0, '0, 1'b0);
    #1;
    checks++;
    if (o_we3 !== 1'b1 || o_addr3 !== 5'd4 || o_rr_ptr !== 2'd0) begin
      failures++;
      $display("FAIL reset_recover got we=%b a=%0d p=%0d exp we=1 a=4 p=0", o_we3, o_addr3, o_rr_ptr);
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) rf_m[r] = '0;
    test_reset();
    test_single();
    test_x0();
    test_stall();
    test_back_to_back();
    test_same_addr();
    test_random();
    test_reset_mid();
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got=%0d pending exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
